// File: rtl/fc_tile_sequencer_pkg.sv
// Shared types and parameter helpers for the fully-connected tile sequencer.
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_COMPUTE, ST_FLUSH, ST_DRAIN, ST_DONE
    } fc_state_t;

    localparam int FC_KERNEL_SIZE = 4096;
    localparam int FC_TILING_SIZE = 8;
    localparam int NUM_TILES      = FC_KERNEL_SIZE / FC_TILING_SIZE;
    localparam int SEL_W          = $clog2(FC_TILING_SIZE);

    // Counters saturate rather than wrap, so every terminal count must fit CNT_W.
    function automatic bit fc_params_ok(int ifm, int kern, int tile, int cnt_w);
        return (cnt_w >= 1) && (cnt_w < 31) && (ifm >= 1) && (ifm < (1 << cnt_w)) &&
               (tile >= 2) && (kern >= tile) && (kern % tile == 0) &&
               (kern / tile <= (1 << cnt_w));
    endfunction

endpackage

// File: rtl/fc_tile_sequencer_tc_counter.sv
// Up-counter with synchronous clear and a terminal-count flag; holds at LAST.
module fc_tc_counter #(
    parameter int W    = 16,
    parameter int LAST = 1
) (
    input  logic         clk1,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == W'(LAST));

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)          cnt <= '0;
        else if (clr)        cnt <= '0;
        else if (inc && !tc) cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/fc_tile_sequencer.sv
// Load/compute/flush/drain sequencer driving an 8-lane FC PE array from one IFM buffer.
module fc_tile_sequencer
    import fc_pkg::*;
#(
    parameter int IFM_SIZE    = 9162,
    parameter int KERNEL_SIZE = 4096,
    parameter int TILING_SIZE = 8,
    parameter int CNT_W       = 16
) (
    input  logic                           clk1,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    input  logic                           ifm_valid,
    output logic                           ifm_ready,
    output logic                           buf_wr_en,
    output logic [CNT_W-1:0]               buf_wr_addr,
    input  logic                           wgt_valid,
    output logic                           wgt_read,
    output logic                           buf_rd_en,
    output logic [CNT_W-1:0]               buf_rd_addr,
    output logic                           pe_en,
    output logic                           psum_clr,
    output logic                           capture,
    output logic [$clog2(TILING_SIZE)-1:0] out_sel,
    output logic                           ofm_valid,
    input  logic                           ofm_ready,
    output logic [CNT_W-1:0]               tile_idx
);

    localparam int TILES  = KERNEL_SIZE / TILING_SIZE;
    localparam int OSEL_W = $clog2(TILING_SIZE);

    generate
        if (!fc_params_ok(IFM_SIZE, KERNEL_SIZE, TILING_SIZE, CNT_W)) begin : g_bad_params
            $error("fc_tile_sequencer: illegal parameter set");
        end
    endgenerate

    fc_state_t state_q, state_d;
    logic      flush2_q;
    logic      start_go, ofm_acc, last_acc, next_tile;
    logic      load_tc, elem_tc, sel_tc, tile_tc;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            flush2_q <= 1'b0;
            pe_en    <= 1'b0;
            psum_clr <= 1'b0;
        end else begin
            state_q  <= state_d;
            flush2_q <= (state_q == ST_FLUSH) && !flush2_q;
            // Buffer read latency is one cycle, so the PE sees each element a cycle late.
            pe_en    <= buf_rd_en;
            psum_clr <= buf_rd_en && (buf_rd_addr == '0);
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = (state_q != ST_IDLE);
        done      = 1'b0;
        ifm_ready = 1'b0;
        wgt_read  = 1'b0;
        capture   = 1'b0;
        ofm_valid = 1'b0;
        start_go  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_go = start;
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                ifm_ready = 1'b1;
                if (ifm_valid && load_tc) state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                wgt_read = wgt_valid;
                if (wgt_valid && elem_tc) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                capture = flush2_q;
                if (flush2_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                ofm_valid = 1'b1;
                if (ofm_ready && sel_tc) state_d = tile_tc ? ST_DONE : ST_COMPUTE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign buf_wr_en = ifm_valid & ifm_ready;
    assign buf_rd_en = wgt_read;
    assign ofm_acc   = ofm_valid & ofm_ready;
    assign last_acc  = ofm_acc & sel_tc;
    assign next_tile = last_acc & ~tile_tc;

    fc_tc_counter #(.W(CNT_W), .LAST(IFM_SIZE-1)) u_load_cnt (
        .clk1(clk1), .rst_n(rst_n), .clr(start_go | (buf_wr_en & load_tc)),
        .inc(buf_wr_en), .cnt(buf_wr_addr), .tc(load_tc));

    fc_tc_counter #(.W(CNT_W), .LAST(IFM_SIZE-1)) u_elem_cnt (
        .clk1(clk1), .rst_n(rst_n), .clr(start_go | next_tile),
        .inc(buf_rd_en), .cnt(buf_rd_addr), .tc(elem_tc));

    fc_tc_counter #(.W(OSEL_W), .LAST(TILING_SIZE-1)) u_sel_cnt (
        .clk1(clk1), .rst_n(rst_n), .clr(start_go | last_acc),
        .inc(ofm_acc), .cnt(out_sel), .tc(sel_tc));

    fc_tc_counter #(.W(CNT_W), .LAST(TILES-1)) u_tile_cnt (
        .clk1(clk1), .rst_n(rst_n), .clr(start_go),
        .inc(last_acc), .cnt(tile_idx), .tc(tile_tc));

endmodule

// File: tb/tb_fc_tile_sequencer.sv
// Bench: sequencer driving a behavioural PE array/IFM buffer; results checked against direct dot products.
module tb_fc_tile_sequencer;
    localparam int L = 4, K = 16, T = 8, CW = 16, NT = K / T, P = L + 2 + T, SW = $clog2(T);
    localparam int MAXC = 64;

    logic clk1 = 1'b0, rst_n = 1'b0;
    always #5 clk1 = ~clk1;

    logic start = 0, ifm_valid = 0, wgt_valid = 0, ofm_ready = 0;
    logic busy, done, ifm_ready, buf_wr_en, wgt_read, buf_rd_en, pe_en, psum_clr, capture, ofm_valid;
    logic [CW-1:0] buf_wr_addr, buf_rd_addr, tile_idx;
    logic [SW-1:0] out_sel;

    logic s_start = 0, s_ifm_valid = 0, s_wgt_valid = 0, s_ofm_ready = 0;
    logic s_busy, s_done, s_ifm_ready, s_buf_wr_en, s_wgt_read, s_buf_rd_en, s_pe_en, s_psum_clr, s_capture, s_ofm_valid;
    logic [CW-1:0] s_buf_wr_addr, s_buf_rd_addr, s_tile_idx;
    logic [2:0] s_out_sel;

    fc_tile_sequencer #(.IFM_SIZE(L), .KERNEL_SIZE(K), .TILING_SIZE(T), .CNT_W(CW)) u_dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
        .wgt_valid(wgt_valid), .wgt_read(wgt_read), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
        .pe_en(pe_en), .psum_clr(psum_clr), .capture(capture), .out_sel(out_sel),
        .ofm_valid(ofm_valid), .ofm_ready(ofm_ready), .tile_idx(tile_idx));

    fc_tile_sequencer #(.IFM_SIZE(1), .KERNEL_SIZE(8), .TILING_SIZE(8), .CNT_W(CW)) u_small (
        .clk1(clk1), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
        .ifm_valid(s_ifm_valid), .ifm_ready(s_ifm_ready), .buf_wr_en(s_buf_wr_en), .buf_wr_addr(s_buf_wr_addr),
        .wgt_valid(s_wgt_valid), .wgt_read(s_wgt_read), .buf_rd_en(s_buf_rd_en), .buf_rd_addr(s_buf_rd_addr),
        .pe_en(s_pe_en), .psum_clr(s_psum_clr), .capture(s_capture), .out_sel(s_out_sel),
        .ofm_valid(s_ofm_valid), .ofm_ready(s_ofm_ready), .tile_idx(s_tile_idx));

    int n_checks = 0, n_pass = 0;

    // Datapath stand-in: IFM buffer, PE lanes, capture registers, weight stream
    int ifm_vec[L];
    int wts[K][L];
    int mem[L];
    int rd_w[T], acc[T], cap[T];
    int rd_ifm, prod_ptr, beat_ptr;
    int got_val[$], got_sel[$], got_tile[$];

    bit tr_busy[MAXC], tr_done[MAXC], tr_ifr[MAXC], tr_wr[MAXC], tr_rd[MAXC], tr_pe[MAXC];
    bit tr_clr[MAXC], tr_cap[MAXC], tr_ov[MAXC], tr_ordy[MAXC], tr_zero[MAXC];
    int tr_wa[MAXC], tr_ra[MAXC], tr_sel[MAXC], tr_tile[MAXC];

    int stall_from = -1, stall_len = 0, start_pulse_c = -1, abort_c = -1;
    bit ofm_alt = 0;

    function automatic int exp_val(int k);
        int s = 0;
        for (int e = 0; e < L; e++) s += ifm_vec[e] * wts[k][e];
        return s;
    endfunction

    task automatic new_job_data();
        for (int e = 0; e < L; e++) ifm_vec[e] = int'($urandom_range(0, 255));
        for (int k = 0; k < K; k++)
            for (int e = 0; e < L; e++) wts[k][e] = int'($urandom_range(0, 255));
        prod_ptr = 0; beat_ptr = 0;
        got_val.delete(); got_sel.delete(); got_tile.delete();
        stall_from = -1; stall_len = 0; start_pulse_c = -1; abort_c = -1; ofm_alt = 0;
    endtask

    // One job of ncyc cycles; cycle 0 is the cycle in which start is high.
    task automatic run_job(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            start     = (c == 0) || (c == start_pulse_c);
            ifm_valid = 1'b1;
            wgt_valid = !(c >= stall_from && c < stall_from + stall_len);
            ofm_ready = ofm_alt ? c[0] : 1'b1;
            if (abort_c >= 0 && c == abort_c)     rst_n = 1'b0;
            if (abort_c >= 0 && c == abort_c + 2) rst_n = 1'b1;
            #1;
            tr_busy[c] = busy; tr_done[c] = done; tr_ifr[c] = ifm_ready; tr_wr[c] = buf_wr_en;
            tr_rd[c] = buf_rd_en & wgt_read; tr_pe[c] = pe_en; tr_clr[c] = psum_clr; tr_cap[c] = capture;
            tr_ov[c] = ofm_valid; tr_ordy[c] = ofm_ready; tr_wa[c] = int'(buf_wr_addr);
            tr_ra[c] = int'(buf_rd_addr); tr_sel[c] = int'(out_sel); tr_tile[c] = int'(tile_idx);
            tr_zero[c] = ({busy, done, ifm_ready, buf_wr_en, buf_wr_addr, wgt_read, buf_rd_en, buf_rd_addr,
                           pe_en, psum_clr, capture, out_sel, ofm_valid, tile_idx} == '0);
            if (rst_n) begin
                if (ofm_valid && ofm_ready) begin
                    got_val.push_back(cap[out_sel]);
                    got_sel.push_back(int'(out_sel));
                    got_tile.push_back(int'(tile_idx));
                end
                if (capture) for (int l = 0; l < T; l++) cap[l] = acc[l];
                if (pe_en) for (int l = 0; l < T; l++) acc[l] = (psum_clr ? 0 : acc[l]) + rd_ifm * rd_w[l];
                if (wgt_read) begin
                    rd_ifm = (buf_rd_addr < L) ? mem[buf_rd_addr] : -1;
                    for (int l = 0; l < T; l++)
                        rd_w[l] = (beat_ptr < NT * L) ? wts[(beat_ptr / L) * T + l][beat_ptr % L] : -1;
                    beat_ptr++;
                end
                if (buf_wr_en) begin
                    if (buf_wr_addr < L) mem[buf_wr_addr] = ifm_vec[prod_ptr % L];
                    prod_ptr++;
                end
            end
            @(posedge clk1); #1;
        end
        start = 0; ifm_valid = 0; wgt_valid = 0; ofm_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = $urandom_range(0, 1); ifm_valid = $urandom_range(0, 1);
            wgt_valid = $urandom_range(0, 1); ofm_ready = $urandom_range(0, 1);
            s_start = $urandom_range(0, 1); s_wgt_valid = $urandom_range(0, 1);
            #1;
            n_checks++;
            if ({busy, done, ifm_ready, buf_wr_en, buf_wr_addr, wgt_read, buf_rd_en, buf_rd_addr, pe_en,
                 psum_clr, capture, out_sel, ofm_valid, tile_idx, s_busy, s_ofm_valid} !== '0)
                $display("FAIL reset_outputs cycle %0d: busy=%b ifm_ready=%b ofm_valid=%b wr_en=%b got nonzero, expected all 0",
                         i, busy, ifm_ready, ofm_valid, buf_wr_en);
            else n_pass++;
            @(posedge clk1); #1;
        end
        start = 0; ifm_valid = 0; wgt_valid = 0; ofm_ready = 0; s_start = 0; s_wgt_valid = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifm_valid = 1'b1; wgt_valid = 1'b1; ofm_ready = 1'b1;
            #1;
            n_checks++;
            if ({busy, ifm_ready, wgt_read, ofm_valid, done} !== 5'b0)
                $display("FAIL idle_no_start cycle %0d: busy/ifr/rd/ov/done=%b expected 00000", i,
                         {busy, ifm_ready, wgt_read, ofm_valid, done});
            else n_pass++;
            @(posedge clk1); #1;
        end
        ifm_valid = 0; wgt_valid = 0; ofm_ready = 0;
    endtask

    task automatic check_words(input string tag);
        n_checks++;
        if (got_val.size() !== K) begin
            $display("FAIL %s word_count: got %0d expected %0d", tag, got_val.size(), K);
            return;
        end
        n_pass++;
        for (int k = 0; k < K; k++) begin
            n_checks++;
            if (got_val[k] !== exp_val(k) || got_sel[k] !== k % T || got_tile[k] !== k / T)
                $display("FAIL %s word%0d: got val=%0d sel=%0d tile=%0d expected val=%0d sel=%0d tile=%0d",
                         tag, k, got_val[k], got_sel[k], got_tile[k], exp_val(k), k % T, k / T);
            else n_pass++;
        end
    endtask

    task automatic test_full_run();
        int d;
        new_job_data();
        run_job(40);
        d = 1 + L + NT * P;
        for (int c = 0; c < 40; c++) begin
            bit eb, ed, ei, er, ep, ec, ek, eo;
            int ra, sel, tl;
            eb = (c >= 1 && c <= d); ed = (c == d); ei = (c >= 1 && c <= L);
            er = 0; ep = 0; ec = 0; ek = 0; eo = 0; ra = 0; sel = 0; tl = 0;
            for (int t = 0; t < NT; t++) begin
                int cs;
                cs = 1 + L + t * P;
                if (c >= cs && c < cs + L) begin er = 1; ra = c - cs; end
                if (c >= cs + 1 && c <= cs + L) ep = 1;
                if (c == cs + 1) ec = 1;
                if (c == cs + L + 1) ek = 1;
                if (c >= cs + L + 2 && c < cs + L + 2 + T) begin eo = 1; sel = c - (cs + L + 2); tl = t; end
            end
            n_checks++;
            if ({tr_busy[c], tr_done[c], tr_ifr[c], tr_wr[c], tr_rd[c], tr_pe[c], tr_clr[c], tr_cap[c], tr_ov[c]} !==
                {eb, ed, ei, ei, er, ep, ec, ek, eo})
                $display("FAIL full_ctrl c%0d: busy,done,ifr,wr,rd,pe,clr,cap,ov=%b expected %b", c,
                         {tr_busy[c], tr_done[c], tr_ifr[c], tr_wr[c], tr_rd[c], tr_pe[c], tr_clr[c], tr_cap[c], tr_ov[c]},
                         {eb, ed, ei, ei, er, ep, ec, ek, eo});
            else n_pass++;
            if (ei) begin
                n_checks++;
                if (tr_wa[c] !== c - 1) $display("FAIL full_wr_addr c%0d: got %0d expected %0d", c, tr_wa[c], c - 1);
                else n_pass++;
            end
            if (er) begin
                n_checks++;
                if (tr_ra[c] !== ra) $display("FAIL full_rd_addr c%0d: got %0d expected %0d", c, tr_ra[c], ra);
                else n_pass++;
            end
            if (eo) begin
                n_checks++;
                if (tr_sel[c] !== sel || tr_tile[c] !== tl)
                    $display("FAIL full_sel c%0d: got sel=%0d tile=%0d expected sel=%0d tile=%0d", c, tr_sel[c], tr_tile[c], sel, tl);
                else n_pass++;
            end
        end
        check_words("full");
    endtask

    task automatic test_wgt_stall();
        int cap_c;
        new_job_data();
        stall_from = 7; stall_len = 3;
        run_job(45);
        for (int c = 7; c <= 9; c++) begin
            n_checks++;
            if (tr_rd[c] !== 1'b0 || tr_ra[c] !== 2)
                $display("FAIL stall_hold c%0d: rd=%b addr=%0d expected rd=0 addr=2", c, tr_rd[c], tr_ra[c]);
            else n_pass++;
        end
        for (int c = 5; c <= 14; c++) begin
            n_checks++;
            if (tr_pe[c] !== (c == 6 || c == 7 || c == 11 || c == 12))
                $display("FAIL stall_pe c%0d: got %b expected %b", c, tr_pe[c], (c == 6 || c == 7 || c == 11 || c == 12));
            else n_pass++;
        end
        cap_c = -1;
        for (int c = 44; c >= 0; c--) if (tr_cap[c] && c < 20) cap_c = c;
        n_checks++;
        if (cap_c !== 13) $display("FAIL stall_capture_cycle: got %0d expected 13", cap_c);
        else n_pass++;
        n_checks++;
        if (tr_done[36] !== 1'b1) $display("FAIL stall_done: done at c36=%b expected 1", tr_done[36]);
        else n_pass++;
        check_words("stall");
    endtask

    task automatic test_back_pressure();
        int ndone;
        new_job_data();
        ofm_alt = 1;
        run_job(55);
        for (int c = 0; c < 54; c++) begin
            if (tr_ov[c] && !tr_ordy[c]) begin
                n_checks++;
                if (tr_ov[c+1] !== 1'b1 || tr_sel[c+1] !== tr_sel[c])
                    $display("FAIL bp_hold c%0d: next ov=%b sel=%0d expected ov=1 sel=%0d", c, tr_ov[c+1], tr_sel[c+1], tr_sel[c]);
                else n_pass++;
            end
        end
        ndone = 0;
        for (int c = 0; c < 55; c++) ndone += int'(tr_done[c]);
        n_checks++;
        if (ndone !== 1 || tr_done[48] !== 1'b1)
            $display("FAIL bp_done: pulses=%0d at48=%b expected 1 pulse at c48", ndone, tr_done[48]);
        else n_pass++;
        check_words("bp");
    endtask

    task automatic test_start_ignored_abort();
        new_job_data();
        start_pulse_c = 6; abort_c = 13;
        run_job(20);
        n_checks++;
        if ({tr_ifr[7], tr_rd[7]} !== 2'b01 || tr_ra[7] !== 2 || tr_ra[8] !== 3)
            $display("FAIL start_ignored: ifr=%b rd=%b addr7=%0d addr8=%0d expected 0 1 2 3",
                     tr_ifr[7], tr_rd[7], tr_ra[7], tr_ra[8]);
        else n_pass++;
        for (int c = 13; c <= 19; c++) begin
            n_checks++;
            if (tr_zero[c] !== 1'b1) $display("FAIL abort_zero c%0d: outputs not all zero, expected 0", c);
            else n_pass++;
        end
        n_checks++;
        if (got_val.size() !== 2 || got_val[0] !== exp_val(0) || got_val[1] !== exp_val(1))
            $display("FAIL abort_partial: got %0d words expected 2 correct words", got_val.size());
        else n_pass++;
        new_job_data();
        run_job(40);
        n_checks++;
        if (tr_done[33] !== 1'b1) $display("FAIL rerun_done: done at c33=%b expected 1", tr_done[33]);
        else n_pass++;
        check_words("rerun");
    endtask

    task automatic test_ifm1();
        int n_rd, n_out, rd_c, pe_c, clr_c, cap_c, done_c;
        n_rd = 0; n_out = 0; rd_c = -1; pe_c = -1; clr_c = -1; cap_c = -1; done_c = -1;
        for (int c = 0; c < 20; c++) begin
            s_start = (c == 0); s_ifm_valid = 1'b1; s_wgt_valid = 1'b1; s_ofm_ready = 1'b1;
            #1;
            if (s_wgt_read) begin n_rd++; rd_c = c; end
            if (s_pe_en) pe_c = c;
            if (s_psum_clr) clr_c = c;
            if (s_capture) cap_c = c;
            if (s_ofm_valid) n_out++;
            if (s_done) done_c = c;
            @(posedge clk1); #1;
        end
        s_start = 0; s_ifm_valid = 0; s_wgt_valid = 0; s_ofm_ready = 0;
        n_checks++;
        if (n_rd !== 1 || rd_c !== 2) $display("FAIL ifm1_read: reads=%0d at c%0d expected 1 at c2", n_rd, rd_c);
        else n_pass++;
        n_checks++;
        if (pe_c !== 3 || clr_c !== 3) $display("FAIL ifm1_pe_clr: pe c%0d clr c%0d expected both c3", pe_c, clr_c);
        else n_pass++;
        n_checks++;
        if (cap_c !== rd_c + 2) $display("FAIL ifm1_capture: got c%0d expected c%0d", cap_c, rd_c + 2);
        else n_pass++;
        n_checks++;
        if (n_out !== 8 || done_c !== 13) $display("FAIL ifm1_drain: outputs=%0d done c%0d expected 8 and c13", n_out, done_c);
        else n_pass++;
    endtask

    initial begin
        @(posedge clk1); #1;
        test_reset();
        test_full_run();
        test_wgt_stall();
        test_back_pressure();
        test_start_ignored_abort();
        test_ifm1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
